sys_array_ctrl: RTL

- Sequencer for an ARRAY_SIZE x ARRAY_SIZE weight-stationary systolic array built from sys_array_cell instances.
- On start, loads one weight row per cycle, then streams num_rows input vectors with per-row diagonal skew.
- Flags which array columns carry valid results each cycle, then pulses done.
- Sits between the host/buffer logic and the array; it drives only control signals, no data.

---
 rtl/sys_array_pkg.sv | 46 ++++
 rtl/sys_array_window.sv | 40 ++++
 rtl/sys_array_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sys_array_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sys_array_pkg
// Brief    : Shared state encoding, width helpers and valid-window function.
// Revision : 1.0 - initial release
// ============================================================================
package sys_array_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } ctrl_state_t;

   localparam int WIN_MAX = 32;

   function automatic int row_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int step_w(input int max_rows, input int n);
      return $clog2(max_rows + 2 * n);
   endfunction

   function automatic int cnt_w(input int max_rows);
      return $clog2(max_rows + 1);
   endfunction

   // Bit j is set when offset+j <= t < offset+j+m; the AND guards the wrap of t-offset-j.
   function automatic logic [WIN_MAX-1:0] win_mask(input logic [31:0] t,
                                                   input logic [31:0] offset,
                                                   input logic [31:0] m,
                                                   input logic [31:0] n);
      logic [WIN_MAX-1:0] mask;
      mask = '0;
      for (int unsigned j = 0; j < WIN_MAX; j++) begin
         if ((j < n) && (t >= offset + j) && ((t - offset - j) < m)) begin
            mask[j] = 1'b1;
         end
      end
      return mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sys_array_window.sv
`default_nettype none
// ============================================================================
// Module   : sys_array_window
// Brief    : Registered per-lane valid mask for a diagonally skewed stream.
// Revision : 1.0 - initial release
// ============================================================================
module sys_array_window
   import sys_array_pkg::*;
#(
   parameter int ARRAY_SIZE = 4,
   parameter int OFFSET     = 0,
   parameter int STEP_W     = 5,
   parameter int CNT_W      = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_en,
   input  logic [STEP_W-1:0]     i_step,
   input  logic [CNT_W-1:0]      i_m,
   output logic [ARRAY_SIZE-1:0] o_mask
);

   logic [ARRAY_SIZE-1:0] w_mask;
   logic [ARRAY_SIZE-1:0] r_mask;

   // Fed with next-cycle step so the registered mask lines up with the step register.
   assign w_mask = ARRAY_SIZE'(win_mask(32'(i_step), 32'(OFFSET), 32'(i_m), 32'(ARRAY_SIZE)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mask <= '0;
      end else begin
         r_mask <= i_en ? w_mask : '0;
      end
   end

   assign o_mask = r_mask;

endmodule
`default_nettype wire

// File: rtl/sys_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sys_array_ctrl
// Brief    : Weight-load / skewed-stream sequencer for an NxN systolic array.
// Revision : 1.0 - initial release
// ============================================================================
module sys_array_ctrl
   import sys_array_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int ARRAY_SIZE = 4,
   parameter  int MAX_ROWS   = 16,
   localparam int ROW_W      = row_w(ARRAY_SIZE),
   localparam int STEP_W     = step_w(MAX_ROWS, ARRAY_SIZE),
   localparam int CNT_W      = cnt_w(MAX_ROWS)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [CNT_W-1:0]      num_rows,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  weight_load,
   output logic [ROW_W-1:0]      weight_row,
   output logic [STEP_W-1:0]     step,
   output logic [ARRAY_SIZE-1:0] in_valid,
   output logic [ARRAY_SIZE-1:0] out_valid
);

   if (ARRAY_SIZE < 2 || DATA_WIDTH < 1) begin : g_param_check
      $error("sys_array_ctrl: ARRAY_SIZE must be >= 2 and DATA_WIDTH >= 1");
   end

   localparam logic [CNT_W-1:0]  c_max_m    = CNT_W'(MAX_ROWS);
   localparam logic [ROW_W-1:0]  c_last_row = ROW_W'(ARRAY_SIZE - 1);
   localparam logic [STEP_W:0]   c_tail     = (STEP_W+1)'(2 * ARRAY_SIZE - 2);

   ctrl_state_t       r_state;
   ctrl_state_t       w_state_nxt;
   logic [CNT_W-1:0]  r_m;
   logic [CNT_W-1:0]  w_m_nxt;
   logic [ROW_W-1:0]  r_row;
   logic [ROW_W-1:0]  w_row_nxt;
   logic [STEP_W-1:0] r_step;
   logic [STEP_W-1:0] w_step_nxt;
   logic [STEP_W:0]   w_last;
   logic              w_err_nxt;
   logic              w_run_nxt;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic              r_wl;

   // One extra bit keeps M+2N-2 from wrapping at the top of the step range.
   assign w_last    = (STEP_W+1)'(r_m) + c_tail;
   assign w_run_nxt = (w_state_nxt == RUN);

   always_comb begin
      w_state_nxt = r_state;
      w_m_nxt     = r_m;
      w_row_nxt   = '0;
      w_step_nxt  = '0;
      w_err_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if ((num_rows != '0) && (num_rows <= c_max_m)) begin
                  w_m_nxt     = num_rows;
                  w_state_nxt = LOAD;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         LOAD: begin
            if (abort) begin
               w_state_nxt = IDLE;
            end else if (r_row == c_last_row) begin
               w_state_nxt = RUN;
            end else begin
               w_row_nxt = r_row + ROW_W'(1);
            end
         end
         RUN: begin
            if (abort) begin
               w_state_nxt = IDLE;
            end else if ({1'b0, r_step} == w_last) begin
               w_state_nxt = DONE;
            end else begin
               w_step_nxt = r_step + STEP_W'(1);
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next-state view so they describe the current cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_m     <= '0;
         r_row   <= '0;
         r_step  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_wl    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_m     <= w_m_nxt;
         r_row   <= w_row_nxt;
         r_step  <= w_step_nxt;
         r_busy  <= (w_state_nxt != IDLE);
         r_done  <= (w_state_nxt == DONE);
         r_err   <= w_err_nxt;
         r_wl    <= (w_state_nxt == LOAD);
      end
   end

   sys_array_window #(
      .ARRAY_SIZE (ARRAY_SIZE),
      .OFFSET     (0),
      .STEP_W     (STEP_W),
      .CNT_W      (CNT_W)
   ) u_in_win (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (w_run_nxt),
      .i_step  (w_step_nxt),
      .i_m     (r_m),
      .o_mask  (in_valid)
   );

   sys_array_window #(
      .ARRAY_SIZE (ARRAY_SIZE),
      .OFFSET     (ARRAY_SIZE),
      .STEP_W     (STEP_W),
      .CNT_W      (CNT_W)
   ) u_out_win (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (w_run_nxt),
      .i_step  (w_step_nxt),
      .i_m     (r_m),
      .o_mask  (out_valid)
   );

   assign busy        = r_busy;
   assign done        = r_done;
   assign err         = r_err;
   assign weight_load = r_wl;
   assign weight_row  = r_row;
   assign step        = r_step;

endmodule
`default_nettype wire
